cim_io_scheduler: RTL
=====================

// Module: cim_io_scheduler
// PURPOSE
//  Sequences one CIM job through the IO path: streams host words into the input FIFO bank
//  round-robin, pulses the CIM start, waits for completion, then drains the output FIFOs
//  round-robin onto a single valid/ready stream. Sits between the host port and the FIFO bank.
//  Replaces per-word host address decoding of FIFO enables during bulk transfers.
// PARAMETERS
//  DATA_IN_WIDTH   36  width of host words / input FIFO write data
//  DATA_OUT_WIDTH  32  width of output FIFO read data / out stream
//  N_IFIFO         16  number of input FIFOs (power of 2)
//  N_OFIFO         2   number of output FIFOs (power of 2, >=2)
//  BURST           4   consecutive words written to one input FIFO before advancing
//  PASS_W          8   width of pass counter / cfg_passes
// PORTS
//  clk            in   1               clock
//  rst            in   1               async reset, active low
//  start          in   1               begin job (sampled in IDLE only)
//  cfg_passes     in   PASS_W          full sweeps over all input FIFOs; latched on start
//  busy           out  1               high in any state except IDLE
//  job_done       out  1               one-cycle pulse at job end
//  in_valid       in   1               host word valid
//  in_data        in   DATA_IN_WIDTH   host word
//  in_ready       out  1               word accepted when in_valid & in_ready
//  ififo_full     in   N_IFIFO         per-input-FIFO full flags
//  ififo_wr_en    out  N_IFIFO         one-hot write enable
//  ififo_wr_data  out  DATA_IN_WIDTH   = in_data (combinational pass-through)
//  cim_start      out  1               one-cycle pulse to CIM array
//  cim_done       in   1               CIM completion (level or pulse)
//  ofifo_empty    in   N_OFIFO         per-output-FIFO empty flags
//  ofifo_rd_en    out  N_OFIFO         one-hot read enable; data valid 1 cycle later
//  ofifo_rd_data  in   DATA_OUT_WIDTH  shared output FIFO read data
//  out_valid      out  1               out stream valid
//  out_data       out  DATA_OUT_WIDTH  registered output word
//  out_src        out  log2(N_OFIFO)   index of FIFO out_data came from
//  out_ready      in   1               downstream accept
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE; all outputs 0; idx, beat, pass, rr, pend cleared.
//  FSM: IDLE -start-> LOAD (or FIRE if cfg_passes==0); LOAD -last word of last pass-> FIRE;
//   FIRE -1 cycle-> WAIT; WAIT -cim_done-> DRAIN; DRAIN -all empty, pend=0, out_valid=0-> DONE;
//   DONE -1 cycle, job_done=1-> IDLE. start ignored outside IDLE; cim_done ignored outside WAIT.
//  LOAD: in_ready = ~ififo_full[idx]; ififo_wr_en[idx] = in_valid & in_ready (same cycle, no
//   latency). Per accepted word: beat++; at beat==BURST-1 -> beat=0, idx++; idx wraps
//   N_IFIFO-1->0 and pass++. Full FIFO stalls (never skipped); order strictly deterministic.
//  Max load rate 1 word/cycle. in_ready=0 in every state but LOAD.
//  DRAIN: single read in flight. Issue rd_en to first non-empty FIFO searching from rr when
//   pend=0 and (out_valid=0 or out_ready=1); set pend=1, rr=selected+1 (mod N_OFIFO).
//   Next cycle: out_data<=ofifo_rd_data, out_src<=sel, out_valid<=1, pend<=0.
//   out_valid holds with stable data until out_ready. Max drain rate 1 word / 2 cycles.
//  Empty flags only evaluated when pend=0 (flag update lag of 1 cycle tolerated).
//  Reset mid-job: immediate abort, no pulses emitted; partially written FIFOs untouched.
// TESTING
//  1. cfg_passes=1, 64 words always valid, no full -> wr_en sequence FIFO0 x4, FIFO1 x4 ..
//     FIFO15 x4, 64 cycles, then cim_start one cycle.
//  2. ififo_full[3]=1 for 10 cycles during FIFO3 burst -> in_ready=0, no wr_en for 10 cycles,
//     then resumes at FIFO3 same beat; no word lost or duplicated.
//  3. cfg_passes=0, start -> cim_start 1 cycle after start, no ififo_wr_en ever.
//  4. cim_done; OFIFO0 holds A,B, OFIFO1 holds C, out_ready=1 -> out stream A(src0),C(src1),
//     B(src0), then job_done pulse, busy=0.
//  5. out_ready=0 for 5 cycles with out_valid=1 -> out_data stable, no ofifo_rd_en issued.
//  6. rst low mid-LOAD and mid-DRAIN -> all outputs 0 asynchronously, IDLE, next start works.

Source files
------------

// File: rtl/cim_io_scheduler.sv
// cim_io_scheduler
// Runs one CIM job end to end. Host words are streamed into the input FIFO bank
// in BURST-sized chunks, round-robin over all input FIFOs, for cfg_passes sweeps.
// The CIM array is then started, and the scheduler waits for completion. Finally
// the output FIFOs are drained round-robin onto a single valid/ready stream.
module cim_io_scheduler #(
    parameter int DATA_IN_WIDTH  = 36,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int N_IFIFO        = 16,
    parameter int N_OFIFO        = 2,
    parameter int BURST          = 4,
    parameter int PASS_W         = 8,
    localparam int SRC_W         = $clog2(N_OFIFO)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [PASS_W-1:0]         i_cfg_passes,
    output logic                      o_busy,
    output logic                      o_job_done,
    input  logic                      i_in_valid,
    input  logic [DATA_IN_WIDTH-1:0]  i_in_data,
    output logic                      o_in_ready,
    input  logic [N_IFIFO-1:0]        i_ififo_full,
    output logic [N_IFIFO-1:0]        o_ififo_wr_en,
    output logic [DATA_IN_WIDTH-1:0]  o_ififo_wr_data,
    output logic                      o_cim_start,
    input  logic                      i_cim_done,
    input  logic [N_OFIFO-1:0]        i_ofifo_empty,
    output logic [N_OFIFO-1:0]        o_ofifo_rd_en,
    input  logic [DATA_OUT_WIDTH-1:0] i_ofifo_rd_data,
    output logic                      o_out_valid,
    output logic [DATA_OUT_WIDTH-1:0] o_out_data,
    output logic [SRC_W-1:0]          o_out_src,
    input  logic                      i_out_ready
);

    localparam int IDX_W  = $clog2(N_IFIFO);
    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_IFIFO - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FIRE  = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                    r_state;
    logic [PASS_W-1:0]         r_passes;
    logic [PASS_W-1:0]         r_pass;
    logic [IDX_W-1:0]          r_idx;
    logic [BEAT_W-1:0]         r_beat;
    logic [SRC_W-1:0]          r_rr;
    logic [SRC_W-1:0]          r_sel;
    logic                      r_pend;
    logic                      r_busy;
    logic                      r_job_done;
    logic                      r_cim_start;
    logic                      r_out_valid;
    logic [DATA_OUT_WIDTH-1:0] r_out_data;
    logic [SRC_W-1:0]          r_out_src;

    logic                      w_in_ready;
    logic                      w_accept;
    logic [N_IFIFO-1:0]        w_wr_en;
    logic                      w_found;
    logic [SRC_W-1:0]          w_sel;
    logic                      w_issue;
    logic [N_OFIFO-1:0]        w_rd_en;

    // Load handshake: the current target FIFO accepts a word whenever it is not full
    always_comb begin
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_wr_en    = '0;
        if (r_state == S_LOAD) begin
            w_in_ready     = ~i_ififo_full[r_idx];
            w_accept       = i_in_valid & w_in_ready;
            w_wr_en[r_idx] = w_accept;
        end else begin
            w_in_ready = 1'b0;
        end
    end

    // Round-robin pick of the first non-empty output FIFO starting at r_rr
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < N_OFIFO; i++) begin
            logic [SRC_W-1:0] cand;
            cand = r_rr + SRC_W'(i);
            if (!w_found && !i_ofifo_empty[cand]) begin
                w_found = 1'b1;
                w_sel   = cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Read issue: one read in flight, only when the output register is free or being freed
    always_comb begin
        w_rd_en = '0;
        w_issue = (r_state == S_DRAIN) && !r_pend && (!r_out_valid || i_out_ready) && w_found;
        if (w_issue) begin
            w_rd_en[w_sel] = 1'b1;
        end else begin
            w_rd_en = '0;
        end
    end

    // Job sequencer: state, counters, pulses and the registered output stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_passes    <= '0;
            r_pass      <= '0;
            r_idx       <= '0;
            r_beat      <= '0;
            r_rr        <= '0;
            r_sel       <= '0;
            r_pend      <= 1'b0;
            r_busy      <= 1'b0;
            r_job_done  <= 1'b0;
            r_cim_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else begin
            r_cim_start <= 1'b0;
            r_job_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_passes <= i_cfg_passes;
                        r_pass   <= '0;
                        r_idx    <= '0;
                        r_beat   <= '0;
                        r_busy   <= 1'b1;
                        if (i_cfg_passes == '0) begin
                            r_state     <= S_FIRE;
                            r_cim_start <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_beat == BEAT_LAST) begin
                            r_beat <= '0;
                            if (r_idx == IDX_LAST) begin
                                r_idx <= '0;
                                if (r_pass == r_passes - PASS_W'(1)) begin
                                    r_state     <= S_FIRE;
                                    r_cim_start <= 1'b1;
                                end else begin
                                    r_pass <= r_pass + PASS_W'(1);
                                end
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                S_FIRE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_cim_done) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_pend) begin
                        // FIFO data arrives one cycle after the read enable
                        r_out_data  <= i_ofifo_rd_data;
                        r_out_src   <= r_sel;
                        r_out_valid <= 1'b1;
                        r_pend      <= 1'b0;
                    end else begin
                        if (r_out_valid && i_out_ready) begin
                            r_out_valid <= 1'b0;
                        end
                        if (w_issue) begin
                            r_pend <= 1'b1;
                            r_sel  <= w_sel;
                            r_rr   <= w_sel + SRC_W'(1);
                        end else if (!w_found && !r_out_valid) begin
                            r_state    <= S_DONE;
                            r_job_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_job_done      = r_job_done;
    assign o_in_ready      = w_in_ready;
    assign o_ififo_wr_en   = w_wr_en;
    assign o_ififo_wr_data = i_in_data;
    assign o_cim_start     = r_cim_start;
    assign o_ofifo_rd_en   = w_rd_en;
    assign o_out_valid     = r_out_valid;
    assign o_out_data      = r_out_data;
    assign o_out_src       = r_out_src;

endmodule
